// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the hh:mm:ss.msec countdown timer. The field widths
// and limits match the time-of-day clock, so preset and display paths can be
// swapped between the two blocks.
//   - field widths      : msec 10, sec 6, min 6, hour 5
//   - field maxima      : 999 / 59 / 59 / 23
//   - state_e           : IDLE, RUN, PAUSE, DONE
// ---------------------------------------------------------------------------
package timer_pkg;

   localparam int MSEC_W = 10;
   localparam int SEC_W  = 6;
   localparam int MIN_W  = 6;
   localparam int HOUR_W = 5;

   localparam int MSEC_MAX = 999;
   localparam int SEC_MAX  = 59;
   localparam int MIN_MAX  = 59;
   localparam int HOUR_MAX = 23;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Clamp an unsigned preset field to its legal maximum.
   function automatic int unsigned clamp(input int unsigned v, input int unsigned max);
      return (v > max) ? max : v;
   endfunction

endpackage

// File: rtl/down_counter.sv
// ---------------------------------------------------------------------------
// down_counter
// One decrementing time field with borrow output. Load has priority over the
// enable. Decrementing from 0 wraps to MAX and signals a borrow to the next
// more-significant field.
// Ports:
//   clk_i       in   clock
//   rst_i       in   asynchronous active-low reset (value -> 0)
//   en_i        in   decrement this cycle
//   load_i      in   load load_value this cycle
//   load_value  in   WIDTH  value to load
//   value       out  WIDTH  current (registered) value
//   borrow_o    out  en_i while value is 0 (the field is about to wrap)
// ---------------------------------------------------------------------------
module down_counter #(
   parameter int          WIDTH = 6,
   parameter int unsigned MAX   = 59
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] value,
   output logic             borrow_o
);

   logic [WIDTH-1:0] value_q;
   logic [WIDTH-1:0] value_d;

   always_comb begin
      value_d = value_q;
      if (load_i) begin
         value_d = load_value;
      end else if (en_i) begin
         value_d = (value_q == '0) ? WIDTH'(MAX) : value_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value    = value_q;
   assign borrow_o = en_i && (value_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
// Decrementing hh:mm:ss.msec timer. The timer is loaded from the preset
// inputs and started or paused by strobes. When it reaches 00:00:00.000 it
// gives a one-cycle done pulse and then holds at zero until the next load.
// Ports:
//   clk_i        in   1   system clock (INPUT_FREQ Hz)
//   rst_i        in   1   asynchronous active-low reset
//   load_i       in   1   load preset fields (saturated), go IDLE
//   start_i      in   1   begin / resume counting
//   pause_i      in   1   suspend counting
//   msec_preset  in   10  preset milliseconds
//   sec_preset   in   6   preset seconds
//   min_preset   in   6   preset minutes
//   hour_preset  in   5   preset hours
//   msec         out  10  current milliseconds
//   sec          out  6   current seconds
//   min          out  6   current minutes
//   hour         out  5   current hours
//   busy_o       out  1   high while counting (RUN)
//   done_o       out  1   one-cycle pulse on expiry
// ---------------------------------------------------------------------------
import timer_pkg::*;

module countdown_timer #(
   parameter int INPUT_FREQ = 50_000_000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              start_i,
   input  logic              pause_i,
   input  logic [MSEC_W-1:0] msec_preset,
   input  logic [SEC_W-1:0]  sec_preset,
   input  logic [MIN_W-1:0]  min_preset,
   input  logic [HOUR_W-1:0] hour_preset,
   output logic [MSEC_W-1:0] msec,
   output logic [SEC_W-1:0]  sec,
   output logic [MIN_W-1:0]  min,
   output logic [HOUR_W-1:0] hour,
   output logic              busy_o,
   output logic              done_o
);

   localparam int MS_CYCLE = INPUT_FREQ / 1000;
   localparam int DIV_W    = (MS_CYCLE > 1) ? $clog2(MS_CYCLE) : 1;

   state_e            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              tick;
   logic              time_zero;
   logic              time_one;
   logic              expire;

   logic              msec_borrow, sec_borrow, min_borrow, hour_borrow;
   logic [MSEC_W-1:0] msec_load;
   logic [SEC_W-1:0]  sec_load;
   logic [MIN_W-1:0]  min_load;
   logic [HOUR_W-1:0] hour_load;

   // Out-of-range presets saturate to the field maximum.
   assign msec_load = MSEC_W'(clamp(32'(msec_preset), MSEC_MAX));
   assign sec_load  = SEC_W'(clamp(32'(sec_preset), SEC_MAX));
   assign min_load  = MIN_W'(clamp(32'(min_preset), MIN_MAX));
   assign hour_load = HOUR_W'(clamp(32'(hour_preset), HOUR_MAX));

   // Millisecond tick: divider is only advanced in RUN, so its partial count
   // survives a pause.
   assign tick      = (state_q == RUN) && (div_q == DIV_W'(MS_CYCLE - 1));
   assign time_zero = (msec == '0) && (sec == '0) && (min == '0) && (hour == '0);
   assign time_one  = (msec == MSEC_W'(1)) && (sec == '0) && (min == '0) && (hour == '0);
   assign expire    = tick && time_one;

   // Time fields, chained by borrows. A load overrides any decrement.
   down_counter #(.WIDTH(MSEC_W), .MAX(MSEC_MAX)) u_msec (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .en_i       (tick && !load_i),
      .load_i     (load_i),
      .load_value (msec_load),
      .value      (msec),
      .borrow_o   (msec_borrow)
   );

   down_counter #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .en_i       (msec_borrow),
      .load_i     (load_i),
      .load_value (sec_load),
      .value      (sec),
      .borrow_o   (sec_borrow)
   );

   down_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .en_i       (sec_borrow),
      .load_i     (load_i),
      .load_value (min_load),
      .value      (min),
      .borrow_o   (min_borrow)
   );

   down_counter #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hour (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .en_i       (min_borrow),
      .load_i     (load_i),
      .load_value (hour_load),
      .value      (hour),
      .borrow_o   (hour_borrow)
   );

   // State, divider and registered outputs.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         div_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next state. Load beats everything. In RUN, reaching zero beats a pause
   // on the same cycle so the timer can never be parked at zero in PAUSE.
   // hour_borrow would mean wrapping below zero; it is folded in as a guard.
   always_comb begin
      state_d = state_q;
      if (load_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start_i && !time_zero) state_d = RUN;
            RUN: begin
               if (expire || hour_borrow) begin
                  state_d = DONE;
               end else if (pause_i) begin
                  state_d = PAUSE;
               end
            end
            PAUSE:   if (start_i) state_d = RUN;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      div_d = div_q;
      if (load_i) begin
         div_d = '0;
      end else if (state_q == RUN) begin
         div_d = tick ? '0 : div_q + DIV_W'(1);
      end
   end

   // Outputs are computed from the next state so they line up with it.
   always_comb begin
      busy_d = (state_d == RUN);
      done_d = (state_q == RUN) && expire && !load_i;
   end

   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
`timescale 1ns/1ps
module tb_countdown_timer;

   localparam int FREQ = 4000;
   localparam int MSC  = FREQ / 1000;

   // Reference-model modes
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   logic       clk = 1'b0;
   logic       rst_i = 1'b0;
   logic       load_i = 1'b0;
   logic       start_i = 1'b0;
   logic       pause_i = 1'b0;
   logic [9:0] msec_preset = '0;
   logic [5:0] sec_preset = '0;
   logic [5:0] min_preset = '0;
   logic [4:0] hour_preset = '0;
   logic [9:0] msec;
   logic [5:0] sec;
   logic [5:0] min;
   logic [4:0] hour;
   logic       busy_o;
   logic       done_o;

   int checks = 0;
   int failures = 0;

   countdown_timer #(.INPUT_FREQ(FREQ)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .load_i      (load_i),
      .start_i     (start_i),
      .pause_i     (pause_i),
      .msec_preset (msec_preset),
      .sec_preset  (sec_preset),
      .min_preset  (min_preset),
      .hour_preset (hour_preset),
      .msec        (msec),
      .sec         (sec),
      .min         (min),
      .hour        (hour),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: remaining time as total ms ----------
   int m_ms   = 0;
   int m_mode = M_IDLE;
   int m_div  = 0;
   bit m_done = 1'b0;

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic int preset_ms();
      return ((sat(int'(hour_preset), 23) * 60 + sat(int'(min_preset), 59)) * 60
              + sat(int'(sec_preset), 59)) * 1000 + sat(int'(msec_preset), 999);
   endfunction

   always @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         m_ms = 0; m_mode = M_IDLE; m_div = 0; m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (load_i) begin
            m_ms = preset_ms(); m_mode = M_IDLE; m_div = 0;
         end else if (m_mode == M_RUN) begin
            if (m_div == MSC - 1) begin
               m_div = 0;
               m_ms  = m_ms - 1;
               if (m_ms == 0) begin
                  m_mode = M_DONE; m_done = 1'b1;
               end
            end else begin
               m_div = m_div + 1;
            end
            if (m_mode == M_RUN && pause_i) m_mode = M_PAUSE;
         end else if (m_mode == M_IDLE) begin
            if (start_i && m_ms != 0) m_mode = M_RUN;
         end else if (m_mode == M_PAUSE) begin
            if (start_i) m_mode = M_RUN;
         end
      end
   end

   // ---------------- per-cycle compare --------------------------------------
   always @(negedge clk) begin
      chk("msec", int'(msec), m_ms % 1000);
      chk("sec",  int'(sec),  (m_ms / 1000) % 60);
      chk("min",  int'(min),  (m_ms / 60000) % 60);
      chk("hour", int'(hour), m_ms / 3600000);
      chk("busy", int'(busy_o), int'(m_mode == M_RUN));
      chk("done", int'(done_o), int'(m_done));
   end

   // ---------------- stimulus -----------------------------------------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_preset(input int h, input int m, input int s, input int ms);
      hour_preset = 5'(h); min_preset = 6'(m); sec_preset = 6'(s); msec_preset = 10'(ms);
   endtask

   task automatic do_load(input int h, input int m, input int s, input int ms);
      set_preset(h, m, s, ms);
      load_i = 1'b1; cyc(1); load_i = 1'b0;
   endtask

   task automatic do_start();
      start_i = 1'b1; cyc(1); start_i = 1'b0;
   endtask

   initial begin
      cyc(3);
      rst_i = 1'b1;
      cyc(1);
      chk("rst_msec", int'(msec), 0);
      chk("rst_hour", int'(hour), 0);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_done", int'(done_o), 0);
      do_start();
      chk("zero_start_busy", int'(busy_o), 0);

      // 3 ms run to expiry
      do_load(0, 0, 0, 3);
      do_start();
      chk("run3_busy", int'(busy_o), 1);
      chk("run3_ms3", int'(msec), 3);
      cyc(4); chk("run3_ms2", int'(msec), 2);
      cyc(4); chk("run3_ms1", int'(msec), 1);
      cyc(4);
      chk("run3_ms0", int'(msec), 0);
      chk("run3_done", int'(done_o), 1);
      chk("run3_busy0", int'(busy_o), 0);
      cyc(1); chk("run3_done_pulse", int'(done_o), 0);
      cyc(20); chk("run3_hold", int'(msec), 0);

      // full borrow chain
      do_load(1, 0, 0, 0);
      do_start();
      cyc(4);
      chk("chain_hour", int'(hour), 0);
      chk("chain_min", int'(min), 59);
      chk("chain_sec", int'(sec), 59);
      chk("chain_msec", int'(msec), 999);

      // pause retains the partial millisecond
      do_load(0, 0, 1, 0);
      do_start();
      cyc(2);
      pause_i = 1'b1; cyc(1); pause_i = 1'b0;
      cyc(10);
      chk("pause_sec", int'(sec), 1);
      chk("pause_msec", int'(msec), 0);
      chk("pause_busy", int'(busy_o), 0);
      do_start();
      chk("resume_sec", int'(sec), 1);
      chk("resume_busy", int'(busy_o), 1);
      cyc(1);
      chk("resume_msec", int'(msec), 999);
      chk("resume_sec0", int'(sec), 0);

      // saturation, then simultaneous strobes
      do_load(31, 60, 63, 1023);
      chk("sat_hour", int'(hour), 23);
      chk("sat_min", int'(min), 59);
      chk("sat_sec", int'(sec), 59);
      chk("sat_msec", int'(msec), 999);
      do_start();
      set_preset(0, 0, 5, 0);
      load_i = 1'b1; pause_i = 1'b1; start_i = 1'b1;
      cyc(1);
      load_i = 1'b0; pause_i = 1'b0; start_i = 1'b0;
      chk("prio_busy", int'(busy_o), 0);
      chk("prio_sec", int'(sec), 5);
      cyc(3);
      chk("prio_idle", int'(busy_o), 0);

      // asynchronous reset mid-run
      do_start();
      cyc(6);
      #2 rst_i = 1'b0;
      #1;
      chk("arst_sec", int'(sec), 0);
      chk("arst_msec", int'(msec), 0);
      chk("arst_busy", int'(busy_o), 0);
      @(negedge clk) rst_i = 1'b1;
      cyc(1);

      // load aborts a run without done
      do_load(0, 0, 0, 2);
      do_start();
      cyc(5);
      chk("abort_pre", int'(msec), 1);
      do_load(0, 0, 3, 0);
      chk("abort_done", int'(done_o), 0);
      chk("abort_busy", int'(busy_o), 0);
      chk("abort_sec", int'(sec), 3);
      cyc(10);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         load_i  = ($urandom_range(0, 99) < 1);
         pause_i = ($urandom_range(0, 99) < 3);
         start_i = ($urandom_range(0, 99) < 12);
         if ($urandom_range(0, 4) == 0)
            set_preset($urandom_range(0, 31), $urandom_range(0, 63),
                       $urandom_range(0, 63), $urandom_range(0, 1023));
         else
            set_preset(0, 0, $urandom_range(0, 1) * $urandom_range(0, 1),
                       $urandom_range(0, 30));
         if (i == 1500) begin
            #2 rst_i = 1'b0;
            #4 rst_i = 1'b1;
         end
         cyc(1);
      end
      load_i = 1'b0; pause_i = 1'b0; start_i = 1'b0;
      cyc(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Decrementing hh:mm:ss.msec timer: the counting-down counterpart of the free-running time-of-day clock.
- Loaded from preset inputs, started and paused by strobes; emits a one-cycle done pulse when it reaches 00:00:00.000, then holds there.
- Sits beside the time-of-day clock and shares its field widths, so preset and display paths are interchangeable.

Parameters:
- INPUT_FREQ, 50_000_000, clk_i frequency in Hz.
- MS_CYCLE, INPUT_FREQ/1000, derived localparam: clk_i cycles per millisecond tick.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-low reset
- load_i  in  1  strobe: load preset fields
- start_i  in  1  strobe: begin or resume counting
- pause_i  in  1  strobe: suspend counting
- msec_preset  in  10  preset milliseconds
- sec_preset  in  6  preset seconds
- min_preset  in  6  preset minutes
- hour_preset  in  5  preset hours
- msec  out  10  current milliseconds, 0..999
- sec  out  6  current seconds, 0..59
- min  out  6  current minutes, 0..59
- hour  out  5  current hours, 0..23
- busy_o  out  1  high while in RUN
- done_o  out  1  one-cycle pulse on expiry

Behaviour:
- Reset (rst_i low, async):
  - all time fields 0; divider 0; state IDLE.
  - busy_o 0; done_o 0.
- States and transitions:
  - IDLE: wait. start_i with a nonzero time -> RUN. start_i with a zero time -> stay in IDLE.
  - RUN: counting. pause_i -> PAUSE.
  - PAUSE: frozen. start_i -> RUN.
  - DONE: fields held at 0. Only load_i leaves this state.
- load_i, any state:
  - next edge loads the preset fields, clears the divider, state -> IDLE.
  - Out-of-range preset fields saturate: msec>999 -> 999, sec>59 -> 59, min>59 -> 59, hour>23 -> 23.
- Strobe priority on the same cycle: load_i > pause_i > start_i. pause_i has no effect outside RUN; start_i has no effect in RUN or DONE.
- Divider:
  - counts 0..MS_CYCLE-1 only in RUN.
  - tick = RUN and divider == MS_CYCLE-1; divider wraps to 0 on tick.
  - Divider value is retained through PAUSE, so the elapsed partial millisecond is not lost.
- Decrement on tick, with a borrow chain:
  - msec: if 0 -> 999 with borrow, else msec-1.
  - sec: on borrow, 0 -> 59 with borrow, else sec-1.
  - min: same rule as sec.
  - hour: on borrow, hour-1. Hour never underflows because expiry is detected first.
- Expiry:
  - A tick while the time is 00:00:00.001 makes the fields read 0 on the next edge.
  - On that same edge: state -> DONE, done_o = 1 for exactly that one cycle, busy_o = 0.
- Latency:
  - busy_o rises on the edge after start_i.
  - First decrement occurs MS_CYCLE cycles after RUN is entered from a cleared divider.
- Mid-operation events:
  - Reset mid-RUN forces the reset values immediately.
  - load_i mid-RUN aborts the count with no done_o.
- All outputs are registered.

Decomposition:
- Package timer_pkg:
  - MSEC_MAX=999, SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - Field widths 10/6/6/5.
  - State enum {IDLE, RUN, PAUSE, DONE}.
- Sub-module down_counter, parameters WIDTH and MAX:
  - inputs en_i, load_i, load_value.
  - outputs value, borrow_o (asserted when en_i and value==0); wraps to MAX.
  - Instantiated four times for the time fields.
- Divider and FSM live in countdown_timer.

Test Plan (INPUT_FREQ=4000, so MS_CYCLE=4):
- Reset release -> all fields 0, busy_o=0, done_o=0. start_i alone -> state stays IDLE.
- Load 00:00:00.003, start -> msec reads 2,1,0 at 4-cycle spacing; done_o high exactly one cycle coincident with 0; busy_o falls; fields stay 0 for a further 20 cycles.
- Load 01:00:00.000, start, one tick -> reads 00:59:59.999 (full borrow chain).
- Load 00:00:01.000, start; pause after 2 cycles, hold 10 cycles, start -> first decrement (to 00:00:00.999) lands 2 cycles after resume, fields frozen throughout the pause.
- Load msec=1023, sec=63, min=60, hour=31 -> reads 23:59:59.999. Then load_i, pause_i and start_i asserted in one cycle -> load wins, state IDLE.
- Mid-RUN rst_i low -> outputs 0 asynchronously. Mid-RUN load_i -> new preset loaded, no done_o, busy_o=0.
